pipelined_cla_adder: RTL

Parametrised, pipelined carry-look-ahead adder/subtractor; next generation of the ALU's fixed 16-bit CLA. Operand width split into SEG_WIDTH-bit look-ahead segments, one segment resolved per pipeline stage, with the carry registered between stages. Valid/ready handshake at both ends; sits between ALU operand select and the result writeback mux. Also produces carry, signed-overflow and zero flags.

---
 rtl/alu_pkg.sv | 10 +
 rtl/cla_segment.sv | 47 ++++
 rtl/pipelined_cla_adder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and default adder geometry.
package alu_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  localparam int ALU_WIDTH     = 16;
  localparam int ALU_SEG_WIDTH = 4;

endpackage

// File: rtl/cla_segment.sv
// Combinational carry-look-ahead segment: every internal carry is a flat
// sum of products of generate/propagate terms, so there is no ripple chain.
module cla_segment #(
  parameter int SEG_WIDTH = 4
) (
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [SEG_WIDTH-1:0] sum,
  output logic                 cout,
  output logic                 p,
  output logic                 g
);

  logic [SEG_WIDTH-1:0] pb;
  logic [SEG_WIDTH-1:0] gb;
  logic [SEG_WIDTH-1:0] c;
  logic                 run;

  assign pb = a ^ b;
  assign gb = a & b;

  // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]cin, expanded per bit
  always_comb begin
    c   = '0;
    g   = 1'b0;
    run = 1'b1;
    for (int i = 0; i < SEG_WIDTH; i++) begin
      run = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        c[i] = c[i] | (gb[j] & run);
        run  = run & pb[j];
      end
      c[i] = c[i] | (run & cin);
    end
    run = 1'b1;
    for (int j = SEG_WIDTH - 1; j >= 0; j--) begin
      g   = g | (gb[j] & run);
      run = run & pb[j];
    end
  end

  assign p    = &pb;
  assign cout = g | (p & cin);
  assign sum  = pb ^ c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor, one look-ahead segment per stage.
// Define ALU_ADD_SATURATE_EN to clamp overflowing results to signed limits.
module pipelined_cla_adder
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int SEG_WIDTH = ALU_SEG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NUM_SEG = WIDTH / SEG_WIDTH;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             carry0;

`ifdef ALU_ADD_SATURATE_EN
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  // Whole pipe moves in lockstep; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = (op == ALU_OP_ADD) ? b   : ~b;
  assign carry0   = (op == ALU_OP_ADD) ? cin : 1'b1;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    localparam int RW = WIDTH - k * SEG_WIDTH;
    localparam int DW = (k + 1) * SEG_WIDTH;

    logic [RW-1:0]        a_i;
    logic [RW-1:0]        b_i;
    logic                 c_i;
    logic                 vld_i;
    logic [SEG_WIDTH-1:0] seg_sum;
    logic                 seg_cout;
    logic                 unused_p;
    logic                 unused_g;
    logic [DW-1:0]        s_o;

    cla_segment #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
      .a    (a_i[SEG_WIDTH-1:0]),
      .b    (b_i[SEG_WIDTH-1:0]),
      .cin  (c_i),
      .sum  (seg_sum),
      .cout (seg_cout),
      .p    (unused_p),
      .g    (unused_g)
    );

    if (k == 0) begin : g_src
      assign a_i   = a;
      assign b_i   = b_eff;
      assign c_i   = carry0;
      assign vld_i = in_valid;
      assign s_o   = seg_sum;
    end else begin : g_src
      assign a_i   = g_stage[k-1].g_reg.a_p;
      assign b_i   = g_stage[k-1].g_reg.b_p;
      assign c_i   = g_stage[k-1].g_reg.c_p;
      assign vld_i = g_stage[k-1].g_reg.vld_p;
      assign s_o   = {seg_sum, g_stage[k-1].g_reg.s_p};
    end

    if (k < NUM_SEG - 1) begin : g_reg
      // ---- stage k -> k+1: resolved low bits plus the unconsumed operands
      logic [RW-SEG_WIDTH-1:0] a_p;
      logic [RW-SEG_WIDTH-1:0] b_p;
      logic [DW-1:0]           s_p;
      logic                    c_p;
      logic                    vld_p;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p <= 1'b0;
        end else if (adv) begin
          vld_p <= vld_i;
        end
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          a_p <= a_i[RW-1:SEG_WIDTH];
          b_p <= b_i[RW-1:SEG_WIDTH];
          s_p <= s_o;
          c_p <= seg_cout;
        end
      end
    end else begin : g_out
      // ---- final stage -> output registers; flags captured with the sum
      logic             ovf_w;
      logic [WIDTH-1:0] res;

      assign ovf_w = (a_i[RW-1] == b_i[RW-1]) && (s_o[WIDTH-1] != a_i[RW-1]);
`ifdef ALU_ADD_SATURATE_EN
      assign res = ovf_w ? sat_value(a_i[RW-1]) : s_o;
`else
      assign res = s_o;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (adv) begin
          out_valid <= vld_i;
          if (vld_i) begin
            sum  <= res;
            cout <= seg_cout;
            ovf  <= ovf_w;
            zero <= ~|res;
          end
        end
      end
    end
  end

endmodule
